// File: rtl/alu_ops_pkg.sv
// Shared ALU operation codes and branch-resolve FSM encoding used by the
// ALU, the ALU control and the branch resolve unit.
package alu_ops_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_BEQ   = 4'b1000;
    localparam logic [3:0] ALU_BNE   = 4'b1001;
    localparam logic [3:0] ALU_BLT   = 4'b1010;
    localparam logic [3:0] ALU_SRA   = 4'b1011;
    localparam logic [3:0] ALU_LUI   = 4'b1100;
    localparam logic [3:0] ALU_JAL   = 4'b1101;
    localparam logic [3:0] ALU_JALR  = 4'b1110;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } brs_state_e;

    // Conditional branches: taken only when the ALU reports the condition true.
    function automatic logic is_cond_branch(input logic [3:0] op);
        logic res;
        case (op)
            ALU_BEQ, ALU_BNE, ALU_BLT: res = 1'b1;
            default:                   res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_jump(input logic [3:0] op);
        logic res;
        case (op)
            ALU_JAL, ALU_JALR: res = 1'b1;
            default:           res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Count register: clear dominates, increment stops at the ceiling.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc && (count_r != COUNT_MAX)) begin
            count_r <= count_r + COUNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches/jumps under static predict-not-taken: registered
// PC redirect, IF/ID and ID/EX flushes, misalignment pulse and statistics.
module branch_resolve_unit
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_ex_i,
    input  logic                  stall_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic                  Zero_i,
    input  logic [DATA_WIDTH-1:0] ALU_Result_i,
    input  logic [DATA_WIDTH-1:0] PC_ex_i,
    input  logic [DATA_WIDTH-1:0] Imm_ex_i,
    output logic                  redirect_o,
    output logic [DATA_WIDTH-1:0] target_pc_o,
    output logic                  flush_if_id_o,
    output logic                  flush_id_ex_o,
    output logic                  misalign_o,
    output logic [CNT_WIDTH-1:0]  branch_count_o,
    output logic [CNT_WIDTH-1:0]  taken_count_o
);

    localparam logic [DATA_WIDTH-1:0] JALR_MASK = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

    brs_state_e            state_r, next_state_s;
    logic                  redirect_r;
    logic                  misalign_r;
    logic [DATA_WIDTH-1:0] target_pc_r;

    logic                  eval_s;
    logic                  taken_s;
    logic                  go_redirect_s;
    logic                  misalign_s;
    logic [DATA_WIDTH-1:0] target_s;

    // Decode: evaluation only in IDLE, so wrong-path shadows in REDIRECT are dropped.
    always_comb begin
        eval_s   = 1'b0;
        taken_s  = 1'b0;
        target_s = PC_ex_i + Imm_ex_i;
        if ((state_r == ST_IDLE) && valid_ex_i && !stall_i
            && (is_cond_branch(ALU_Operation_i) || is_jump(ALU_Operation_i))) begin
            eval_s = 1'b1;
        end else begin
            eval_s = 1'b0;
        end
        if (is_jump(ALU_Operation_i)) begin
            taken_s = 1'b1;
        end else if (is_cond_branch(ALU_Operation_i)) begin
            taken_s = Zero_i;
        end else begin
            taken_s = 1'b0;
        end
        case (ALU_Operation_i)
            ALU_JALR: target_s = ALU_Result_i & JALR_MASK;
            default:  target_s = PC_ex_i + Imm_ex_i;
        endcase
    end

    assign go_redirect_s = eval_s && taken_s && (target_s[1:0] == 2'b00);
    assign misalign_s    = eval_s && taken_s && (target_s[1:0] != 2'b00);

    // Next-state: a redirect is held for as long as the pipeline is stalled.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (go_redirect_s) begin
                    next_state_s = ST_REDIRECT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (stall_i) begin
                    next_state_s = ST_REDIRECT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State and registered outputs; target only updates on a new redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            redirect_r  <= 1'b0;
            misalign_r  <= 1'b0;
            target_pc_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r     <= next_state_s;
            redirect_r  <= (next_state_s == ST_REDIRECT);
            misalign_r  <= misalign_s;
            target_pc_r <= go_redirect_s ? target_s : target_pc_r;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (eval_s),
        .count (branch_count_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (eval_s && taken_s),
        .count (taken_count_o)
    );

    assign redirect_o    = redirect_r;
    assign flush_if_id_o = redirect_r;
    assign flush_id_ex_o = redirect_r;
    assign misalign_o    = misalign_r;
    assign target_pc_o   = target_pc_r;

endmodule
